// File: rtl/uart_pixel_cmd.sv
// uart_pixel_cmd: packet decoder between the UART receiver and the framebuffer write port.
// Assembles A5-framed pixel packets, validates range (and optionally checksum), and issues
// one-cycle pixel writes. Bad or stalled packets raise a one-cycle error and are counted.
//
// Optional feature macro: UART_PIXEL_CHECKSUM_EN
//   defined   -> packet A5, X, Y, COLOR, CHK with CHK = X ^ Y ^ COLOR
//   undefined -> packet A5, X, Y, COLOR (range and timeout errors only)
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Rx_DV      one-cycle byte valid strobe from the UART receiver
//   i_Rx_Byte    received byte, valid with i_Rx_DV
//   o_Pix_Wr     one-cycle pixel write strobe
//   o_Pix_X/Y    pixel coordinates, held until the next write
//   o_Pix_Color  RGB332 colour, held until the next write
//   o_Err        one-cycle error pulse (checksum, range, timeout)
//   o_Err_Count  saturating error count, cleared only by reset
//   o_Busy       high while a packet is in progress
module uart_pixel_cmd #(
   parameter int unsigned H_PIX        = 160,
   parameter int unsigned V_PIX        = 120,
   parameter int unsigned TIMEOUT_CLKS = 21700
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Pix_Wr,
   output logic [7:0] o_Pix_X,
   output logic [7:0] o_Pix_Y,
   output logic [7:0] o_Pix_Color,
   output logic       o_Err,
   output logic [7:0] o_Err_Count,
   output logic       o_Busy
);

   localparam int unsigned TW     = $clog2(TIMEOUT_CLKS) + 1;
   localparam logic [7:0]  SYNC   = 8'hA5;
   localparam logic [8:0]  H_LIM  = 9'(H_PIX);
   localparam logic [8:0]  V_LIM  = 9'(V_PIX);
   localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      StIdle, StGetX, StGetY, StGetColor, StGetChk, StDone
   } state_e;

   state_e        r_State, w_State_Next;
   logic [TW-1:0] r_Timer, w_Timer_Next;
   logic [7:0]    r_X, r_Y, r_Color;
   logic          r_Pix_Wr, r_Err;
   logic [7:0]    r_Pix_X, r_Pix_Y, r_Pix_Color, r_Err_Count;
   logic          w_In_Get, w_Timeout, w_Chk_Ok, w_Good, w_Err_Set;

`ifdef UART_PIXEL_CHECKSUM_EN
   logic [7:0] r_Chk;
   assign w_Chk_Ok = (r_Chk == (r_X ^ r_Y ^ r_Color));
`else
   assign w_Chk_Ok = 1'b1;
`endif

   assign w_In_Get  = (r_State == StGetX) || (r_State == StGetY) ||
                      (r_State == StGetColor) || (r_State == StGetChk);
   // A byte landing on the terminal count still wins over the timeout.
   assign w_Timeout = w_In_Get && !i_Rx_DV && (r_Timer == T_END);
   assign w_Good    = w_Chk_Ok && ({1'b0, r_X} < H_LIM) && ({1'b0, r_Y} < V_LIM);
   assign w_Err_Set = ((r_State == StDone) && !w_Good) || w_Timeout;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State <= StIdle;
         r_Timer <= '0;
      end else begin
         r_State <= w_State_Next;
         r_Timer <= w_Timer_Next;
      end
   end

   always_comb begin
      w_State_Next = r_State;
      w_Timer_Next = '0;
      if (w_In_Get && !i_Rx_DV) w_Timer_Next = r_Timer + 1'b1;
      case (r_State)
         StIdle:     if (i_Rx_DV && (i_Rx_Byte == SYNC)) w_State_Next = StGetX;
         StGetX:     if (i_Rx_DV) w_State_Next = StGetY;
         StGetY:     if (i_Rx_DV) w_State_Next = StGetColor;
`ifdef UART_PIXEL_CHECKSUM_EN
         StGetColor: if (i_Rx_DV) w_State_Next = StGetChk;
         StGetChk:   if (i_Rx_DV) w_State_Next = StDone;
`else
         StGetColor: if (i_Rx_DV) w_State_Next = StDone;
`endif
         StDone:     w_State_Next = StIdle;
         default:    w_State_Next = StIdle;
      endcase
      if (w_Timeout) w_State_Next = StIdle;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_X         <= '0;
         r_Y         <= '0;
         r_Color     <= '0;
`ifdef UART_PIXEL_CHECKSUM_EN
         r_Chk       <= '0;
`endif
         r_Pix_Wr    <= 1'b0;
         r_Err       <= 1'b0;
         r_Pix_X     <= '0;
         r_Pix_Y     <= '0;
         r_Pix_Color <= '0;
         r_Err_Count <= '0;
      end else begin
         r_Pix_Wr <= 1'b0;
         r_Err    <= w_Err_Set;
         if (i_Rx_DV) begin
            if (r_State == StGetX)     r_X     <= i_Rx_Byte;
            if (r_State == StGetY)     r_Y     <= i_Rx_Byte;
            if (r_State == StGetColor) r_Color <= i_Rx_Byte;
`ifdef UART_PIXEL_CHECKSUM_EN
            if (r_State == StGetChk)   r_Chk   <= i_Rx_Byte;
`endif
         end
         if ((r_State == StDone) && w_Good) begin
            r_Pix_Wr    <= 1'b1;
            r_Pix_X     <= r_X;
            r_Pix_Y     <= r_Y;
            r_Pix_Color <= r_Color;
         end
         if (w_Err_Set && (r_Err_Count != 8'hFF)) r_Err_Count <= r_Err_Count + 1'b1;
      end
   end

   assign o_Pix_Wr    = r_Pix_Wr;
   assign o_Pix_X     = r_Pix_X;
   assign o_Pix_Y     = r_Pix_Y;
   assign o_Pix_Color = r_Pix_Color;
   assign o_Err       = r_Err;
   assign o_Err_Count = r_Err_Count;
   assign o_Busy      = (r_State != StIdle);

endmodule

// File: tb/tb_uart_pixel_cmd.sv
// Scoreboard bench for uart_pixel_cmd: stimulus pushes expected write/error events,
// a negedge monitor pops and compares whenever o_Pix_Wr or o_Err is seen.
module tb_uart_pixel_cmd;

   localparam int unsigned TO = 21700;
`ifdef UART_PIXEL_CHECKSUM_EN
   localparam bit BAD_CHK_OK = 1'b0;
`else
   localparam bit BAD_CHK_OK = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dv  = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       pix_wr, err, busy;
   logic [7:0] pix_x, pix_y, pix_c, err_cnt;

   uart_pixel_cmd #(
      .H_PIX(160),
      .V_PIX(120),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .i_Clock(clk),
      .i_Reset(rst),
      .i_Rx_DV(dv),
      .i_Rx_Byte(rx_byte),
      .o_Pix_Wr(pix_wr),
      .o_Pix_X(pix_x),
      .o_Pix_Y(pix_y),
      .o_Pix_Color(pix_c),
      .o_Err(err),
      .o_Err_Count(err_cnt),
      .o_Busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] c;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m_x = 0, m_y = 0, m_c = 0, m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe cycle must match the oldest expected event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pix_wr || err) begin
            chk("wr_err_exclusive", {31'd0, pix_wr & err}, 32'd0);
            if (q.size() == 0) begin
               chk("unexpected_event", {30'd0, pix_wr, err}, 32'd0);
            end else begin
               e = q.pop_front();
               chk("event_is_err", {31'd0, err}, {31'd0, e.is_err});
               chk("pix_x", {24'd0, pix_x}, {24'd0, e.x});
               chk("pix_y", {24'd0, pix_y}, {24'd0, e.y});
               chk("pix_color", {24'd0, pix_c}, {24'd0, e.c});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      dv = 1'b1;
      rx_byte = b;
      @(negedge clk);
      dv = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic expect_evt(input bit ok, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] c);
      if (ok) begin
         m_x = x;
         m_y = y;
         m_c = c;
         q.push_back({1'b0, x, y, c});
      end else begin
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
         q.push_back({1'b1, m_x, m_y, m_c});
      end
   endtask

   // g0: gap after sync, g: gap after every other byte (>= 1 so the count has settled).
   task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                           input logic [7:0] ck, input bit ok, input int g0, input int g);
      send_byte(8'hA5, g0);
      send_byte(x, g);
      send_byte(y, g);
`ifdef UART_PIXEL_CHECKSUM_EN
      send_byte(c, g);
      expect_evt(ok, x, y, c);
      send_byte(ck, g);
`else
      expect_evt(ok, x, y, c);
      send_byte(c, g);
`endif
      chk("err_count", {24'd0, err_cnt}, {24'd0, m_cnt});
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pix_wr", {31'd0, pix_wr}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err_count", {24'd0, err_cnt}, 32'd0);
      chk("rst_pix_xyc", {8'd0, pix_x, pix_y, pix_c}, 32'd0);

      // Valid packet at realistic UART spacing.
      send_byte(8'hA5, 0);
      chk("busy_after_sync", {31'd0, busy}, 32'd1);
      repeat (2168) @(negedge clk);
      send_byte(8'h10, 2168);
      send_byte(8'h20, 2168);
`ifdef UART_PIXEL_CHECKSUM_EN
      send_byte(8'h3C, 2168);
      expect_evt(1'b1, 8'h10, 8'h20, 8'h3C);
      send_byte(8'h0C, 4);
`else
      expect_evt(1'b1, 8'h10, 8'h20, 8'h3C);
      send_byte(8'h3C, 4);
`endif
      chk("busy_after_pkt", {31'd0, busy}, 32'd0);
      chk("err_count_0", {24'd0, err_cnt}, 32'd0);

      send_pkt(8'h10, 8'h20, 8'h3C, 8'h0D, BAD_CHK_OK, 3, 3);   // bad checksum
      send_pkt(8'hA0, 8'h20, 8'h3C, 8'h8C, 1'b0, 3, 3);         // X = 160
      send_pkt(8'h9F, 8'h77, 8'hFF, 8'h17, 1'b1, 3, 3);         // corner in range
      send_pkt(8'h9F, 8'h78, 8'hFF, 8'h10, 1'b0, 3, 3);         // Y = 120

      // Timeout: sync + X then silence.
      send_byte(8'hA5, 2);
      send_byte(8'h10, 0);
      expect_evt(1'b0, 8'h00, 8'h00, 8'h00);
      n = 0;
      while (!err && n < TO + 10) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency", n, TO);
      @(negedge clk);
      chk("busy_after_timeout", {31'd0, busy}, 32'd0);
      send_pkt(8'h05, 8'h06, 8'h07, 8'h04, 1'b1, 3, 3);

      // Byte exactly on the terminal count is accepted.
      send_pkt(8'h11, 8'h22, 8'h33, 8'h00, 1'b1, TO - 2, 3);

      // Garbage then a valid packet; data A5 inside a packet.
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      send_byte(8'h13, 1);
      send_pkt(8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 3, 3);
      send_pkt(8'hA5, 8'h01, 8'h02, 8'hA6, 1'b0, 3, 3);

      // Reset mid-packet.
      send_byte(8'hA5, 1);
      send_byte(8'h10, 1);
      send_byte(8'h20, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_x = 0; m_y = 0; m_c = 0; m_cnt = 0;
      chk("busy_after_reset", {31'd0, busy}, 32'd0);
      chk("err_after_reset", {31'd0, err}, 32'd0);
      chk("count_after_reset", {24'd0, err_cnt}, 32'd0);
      repeat (10) @(negedge clk);

      // Saturation.
      for (int i = 0; i < 300; i++) send_pkt(8'hA0, 8'h20, 8'h3C, 8'h8C, 1'b0, 1, 1);
      chk("err_count_sat", {24'd0, err_cnt}, 32'd255);

      repeat (20) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
